// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if
//
// Purpose:
//   Bundles the request, HI/LO move and result signals between the CPU
//   controller / register file and the iterative multiply/divide unit.
//
// Signals:
//   start       : request a new operation (honoured only while not busy)
//   op          : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a   : rs value (multiplicand / dividend)
//   operand_b   : rt value (multiplier / divisor)
//   hi_write    : MTHI strobe
//   lo_write    : MTLO strobe
//   hilo_wdata  : data for MTHI / MTLO
//   busy        : operation in progress, controller must stall
//   done        : one-cycle pulse when a new result sits in HI/LO
//   hi, lo      : architectural HI and LO registers
//
// Modports:
//   master : controller side, drives requests and observes results
//   slave  : multiply/divide unit side
// -----------------------------------------------------------------------------
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             hi_write;
    logic             lo_write;
    logic [WIDTH-1:0] hilo_wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, hi_write, lo_write, hilo_wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, hi_write, lo_write, hilo_wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Purpose:
//   Iterative HI/LO multiply/divide unit for the multi-cycle CPU. On start it
//   latches the operands (as magnitudes for signed ops, with result-sign
//   flags), runs WIDTH iterations of shift-add multiply or restoring divide,
//   then spends one FIX cycle applying the sign correction and committing the
//   result into HI/LO. MTHI/MTLO write HI/LO directly while idle.
//
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   reset  : synchronous active-high reset, returns to IDLE and clears HI/LO
//   bus    : mult_div_unit_if slave modport (requests, MT strobes, results)
//
// Timing:
//   Start sampled at edge E0, iterations on E1..E(WIDTH), commit on
//   E(WIDTH+1); done pulses for one cycle afterwards, in which a new start is
//   already accepted.
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    mult_div_unit_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       op_q, op_d;
    // Multiplicand for multiply, divisor for divide (always a magnitude)
    logic [WIDTH-1:0] mcand_q, mcand_d;
    // Upper half of the product, or the partial remainder
    logic [WIDTH-1:0] acc_q, acc_d;
    // Multiplier shifting out / product low half, or dividend shifting out /
    // quotient shifting in
    logic [WIDTH-1:0] low_q, low_d;
    logic             negProd_q, negProd_d;
    logic             negRem_q, negRem_d;
    logic             divZero_q, divZero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             isSigned;
    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;

    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic             divFits;
    logic [WIDTH-1:0] divRem;

    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] productFixed;
    logic [WIDTH-1:0]   quotFixed;
    logic [WIDTH-1:0]   remFixed;

    // Operand preparation for the start cycle. Signed ops work on magnitudes;
    // the most negative value negates to itself, which is still the correct
    // unsigned magnitude.
    assign isSigned = ~bus.op[0];
    assign aNeg     = isSigned & bus.operand_a[WIDTH-1];
    assign bNeg     = isSigned & bus.operand_b[WIDTH-1];
    assign absA     = aNeg ? (-bus.operand_a) : bus.operand_a;
    assign absB     = bNeg ? (-bus.operand_b) : bus.operand_b;

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole product right by one
    // with the carry entering at the top.
    assign mulSum = {1'b0, acc_q} + (low_q[0] ? {1'b0, mcand_q} : '0);

    // One restoring-divide step: bring the next dividend bit into the partial
    // remainder and subtract the divisor only if it fits. A zero divisor
    // always fits, giving an all-ones quotient and the dividend as remainder.
    assign divShift = {acc_q, low_q[WIDTH-1]};
    assign divFits  = (divShift >= {1'b0, mcand_q});
    assign divRem   = divFits ? WIDTH'(divShift - {1'b0, mcand_q}) : divShift[WIDTH-1:0];

    // Sign correction applied in the FIX cycle
    assign product      = {acc_q, low_q};
    assign productFixed = negProd_q ? (-product) : product;
    assign quotFixed    = negProd_q ? (-low_q) : low_q;
    assign remFixed     = negRem_q ? (-acc_q) : acc_q;

    // State register for the FSM and all datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            op_q      <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            low_q     <= '0;
            negProd_q <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            low_q     <= low_d;
            negProd_q <= negProd_d;
            negRem_q  <= negRem_d;
            divZero_q <= divZero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath control. HI/LO only change on MTHI/MTLO in IDLE
    // or on the FIX commit, so their old values stay visible throughout CALC.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        low_d     = low_q;
        negProd_d = negProd_q;
        negRem_d  = negRem_q;
        divZero_d = divZero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Start takes priority; any MT strobe in this cycle is dropped
                    op_d      = bus.op;
                    acc_d     = '0;
                    negProd_d = aNeg ^ bNeg;
                    negRem_d  = aNeg;
                    divZero_d = bus.op[1] & (bus.operand_b == '0);
                    count_d   = '0;
                    if (bus.op[1]) begin
                        mcand_d = absB;
                        low_d   = absA;
                    end else begin
                        mcand_d = absA;
                        low_d   = absB;
                    end
                    state_d = CALC;
                end else begin
                    if (bus.hi_write) begin
                        hi_d = bus.hilo_wdata;
                    end
                    if (bus.lo_write) begin
                        lo_d = bus.hilo_wdata;
                    end
                end
            end

            CALC: begin
                if (op_q[1]) begin
                    acc_d = divRem;
                    low_d = {low_q[WIDTH-2:0], divFits};
                end else begin
                    acc_d = mulSum[WIDTH:1];
                    low_d = {mulSum[0], low_q[WIDTH-1:1]};
                end
                count_d = count_q + 1'b1;
                if (count_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (op_q[1]) begin
                    // A zero divisor reports an all-ones quotient regardless of
                    // sign; the remainder path already reproduces operand_a.
                    lo_d = divZero_q ? '1 : quotFixed;
                    hi_d = remFixed;
                end else begin
                    hi_d = productFixed[2*WIDTH-1:WIDTH];
                    lo_d = productFixed[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative HI/LO multiply/divide unit for the multi-cycle CPU. It sits directly downstream of the register file: it latches the two register read ports as operands on `start`, then computes MULT/MULTU/DIV/DIVU over 33 cycles into its own HI/LO registers. The controller stalls on `busy`, and MFHI/MFLO later route `hi`/`lo` back toward the register-file write-data mux.

## Interface
- `WIDTH`, 32, operand and HI/LO width; the iteration count equals `WIDTH`.
- `clk` input 1: system clock; all state updates on posedge.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `start` input 1: request a new operation; sampled only when `busy`=0.
- `op` input 2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `operand_a` input WIDTH: rs value, i.e. register-file Read_data1 (multiplicand/dividend).
- `operand_b` input WIDTH: rt value, i.e. register-file Read_data2 (multiplier/divisor).
- `hi_write` input 1: MTHI strobe.
- `lo_write` input 1: MTLO strobe.
- `hilo_wdata` input WIDTH: data for MTHI/MTLO.
- `busy` output 1: operation in progress; the controller must stall MFHI/MFLO/mult/div.
- `done` output 1: one-cycle pulse; `hi`/`lo` hold the new result.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- States are IDLE, CALC and FIX. A counter counts 0..WIDTH-1 in CALC.
- **IDLE, `start`=1:**
  - Latch `op`.
  - For signed ops, latch |operand_a| and |operand_b|, plus the result-sign flags:
    - product/quotient negative = sign(a) XOR sign(b);
    - remainder negative = sign(a).
  - Clear the counter and go to CALC.
- **CALC, multiply:** radix-2 shift-add on the unsigned magnitudes, forming a 2·WIDTH-bit product.
- **CALC, divide:** restoring division on the unsigned magnitudes, producing a WIDTH-bit quotient and remainder.
- **CALC exit:** leave for FIX after WIDTH iterations.
- **FIX (one cycle):**
  - Apply the sign correction by two's-complement negation.
  - Multiply: {hi,lo} ← product.
  - Divide: lo ← quotient, hi ← remainder.
  - Go to IDLE and set `done` for the next cycle.
- **Divide by zero (DIV or DIVU):** lo = all ones, hi = operand_a. No trap is raised.
- **DIV 0x80000000 / 0xFFFFFFFF:** lo = 0x80000000, hi = 0. This is the natural result of the magnitude algorithm plus sign fix and must not hang.
- **MULT/MULTU boundaries:** results are exact; no overflow flag exists.
- **MTHI/MTLO:**
  - In IDLE with `start`=0, `hi_write` loads `hi` from `hilo_wdata` and `lo_write` loads `lo`. Both strobes may be active in the same cycle.
  - Ignored while `busy`=1.
- **Simultaneous events:**
  - `start` and `hi_write`/`lo_write` in the same IDLE cycle: `start` wins and the writes are dropped.
  - `start` while `busy`=1 is ignored. Operands are not re-latched.
- **Operand stability:** `hi`/`lo` are not modified during CALC. The old values stay readable until the FIX commit.
- **Reset (any state, including mid-operation):**
  - state → IDLE; counter, `hi`, `lo` → 0.
  - `busy` → 0, `done` → 0.
  - The in-flight operation is discarded.

## Timing
- Let E0 be the edge that samples `start`=1 in IDLE.
- `busy` = 1 from after E0 through the edge E0+33. It is combinationally high in CALC and FIX, and is 0 in IDLE.
- Edges E1..E32 perform the 32 iterations. The FIX commit happens at E33.
- After E33, `hi`/`lo` hold the result and `done` = 1 for exactly one cycle (registered). `busy` = 0 in that same cycle.
- Start-to-result latency is 33 cycles. A back-to-back `start` is accepted in the `done` cycle.
- MTHI/MTLO take effect after one edge.
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0.

## Test plan
- **Unsigned multiply:** MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; `done` high one cycle; `busy` high exactly 33 cycles.
- **Signed multiply:** MULT −3 (0xFFFFFFFD) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- **Signed divide:**
  - DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- **Unsigned divide and divide by zero:**
  - DIVU 100 / 7 → lo=14, hi=2.
  - DIVU 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x1234.
- **MT and start arbitration:**
  - MTLO 0xABCD in IDLE → lo=0xABCD next cycle.
  - MTHI while busy → no change.
  - `start` with `hi_write` in the same cycle → the operation runs and the write is dropped.
  - A second `start` mid-CALC → ignored; the result matches the first operands.
- **Reset mid-operation:** reset at E0+10 → next cycle busy=0, done=0, hi=lo=0. A fresh MULTU 6×7 afterwards gives lo=42, hi=0.
